// File: rtl/led_blink_timebase.sv
// Blink-phase timebase: divides SYSCLK into a 25 ms tick and decodes shared LED blink patterns.
// Optional macro LED_BLINK_SYNC_EN lets BLINK_SYNC restart the blink phase.
module led_blink_timebase #(
    parameter int TICK_DIV = 625000
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic BLINK_SYNC,
    output logic TICK_25MS,
    output logic CLK_1HZ,
    output logic CLK_2HZ,
    output logic CLK_4HZ,
    output logic CLK_4HZ_500MS,
    output logic CLK_4HZ_3500MS,
    output logic CLK_07S
);

    localparam int FRAME_TICKS = 160;
    localparam int C07_TICKS   = 56;
    localparam int PW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]    F_MAX    = 8'(FRAME_TICKS - 1);
    localparam logic [5:0]    C07_MAX  = 6'(C07_TICKS - 1);
    localparam logic [5:0]    C07_HALF = 6'(C07_TICKS / 2);

    logic [PW-1:0] pcnt;
    logic [7:0]    f;
    logic [5:0]    c07;
    logic [3:0]    m10;
    logic [4:0]    m20;
    logic [5:0]    m40;
    logic          restart;

`ifdef LED_BLINK_SYNC_EN
    assign restart = BLINK_SYNC;
`else
    logic unused_blink_sync;
    assign unused_blink_sync = BLINK_SYNC;
    assign restart = 1'b0;
`endif

    // A restart clears the counters exactly like reset and drops any coinciding tick.
    always_ff @(posedge SYSCLK) begin
        if (RESET || restart) begin
            pcnt      <= '0;
            TICK_25MS <= 1'b0;
            f         <= '0;
            c07       <= '0;
            m10       <= '0;
            m20       <= '0;
            m40       <= '0;
        end else begin
            if (pcnt == PCNT_MAX) begin
                pcnt      <= '0;
                TICK_25MS <= 1'b1;
            end else begin
                pcnt      <= pcnt + 1'b1;
                TICK_25MS <= 1'b0;
            end

            if (TICK_25MS) begin
                f   <= (f   == F_MAX)   ? 8'd0 : f   + 8'd1;
                c07 <= (c07 == C07_MAX) ? 6'd0 : c07 + 6'd1;
                m10 <= (m10 == 4'd9)    ? 4'd0 : m10 + 4'd1;
                m20 <= (m20 == 5'd19)   ? 5'd0 : m20 + 5'd1;
                m40 <= (m40 == 6'd39)   ? 6'd0 : m40 + 6'd1;
            end
        end
    end

    // Lit phase is the second half of each period, so zeroed counters decode to all-dark.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            CLK_1HZ        <= 1'b0;
            CLK_2HZ        <= 1'b0;
            CLK_4HZ        <= 1'b0;
            CLK_4HZ_500MS  <= 1'b0;
            CLK_4HZ_3500MS <= 1'b0;
            CLK_07S        <= 1'b0;
        end else begin
            CLK_1HZ        <= (m40 >= 6'd20);
            CLK_2HZ        <= (m20 >= 5'd10);
            CLK_4HZ        <= (m10 >= 4'd5);
            CLK_4HZ_500MS  <= (m10 >= 4'd5) && (f < 8'd20);
            CLK_4HZ_3500MS <= (m10 >= 4'd5) && (f < 8'd140);
            CLK_07S        <= (c07 >= C07_HALF);
        end
    end

endmodule

// File: tb/tb_led_blink_timebase.sv
// Directed bench for led_blink_timebase with TICK_DIV=4 (one tick every 4 SYSCLK cycles).
// Honours LED_BLINK_SYNC_EN to choose the expected BLINK_SYNC behaviour.
module tb_led_blink_timebase;

    logic SYSCLK = 1'b0;
    logic RESET;
    logic BLINK_SYNC;
    logic TICK_25MS, CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S;

    int errors = 0;
    int checks = 0;

    // Hand-computed observations: edge index after release -> {tick,1hz,2hz,4hz,500ms,3500ms,07s}
    int         tabE [7] = '{21, 22, 24, 42, 114, 4481, 4482};
    logic [6:0] tabV [7] = '{7'b0000000, 7'b0001110, 7'b1001110, 7'b0010000,
                             7'b0101011, 7'b0111001, 7'b0000000};

    int riseE [3][2];
    int riseN [3];
    int n500, n3500;
    int s07, rise07a, fall07, rise07b;

    led_blink_timebase #(.TICK_DIV(4)) dut (
        .SYSCLK(SYSCLK),
        .RESET(RESET),
        .BLINK_SYNC(BLINK_SYNC),
        .TICK_25MS(TICK_25MS),
        .CLK_1HZ(CLK_1HZ),
        .CLK_2HZ(CLK_2HZ),
        .CLK_4HZ(CLK_4HZ),
        .CLK_4HZ_500MS(CLK_4HZ_500MS),
        .CLK_4HZ_3500MS(CLK_4HZ_3500MS),
        .CLK_07S(CLK_07S)
    );

    always #5 SYSCLK = ~SYSCLK;

    function automatic logic [6:0] obsVec();
        return {TICK_25MS, CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S};
    endfunction

    // Edge e after release: tick n is high after edge 4n, outputs show f=n from edge 4n+2.
    function automatic logic [6:0] expVec(input int e);
        int t, f, c;
        logic tick, hz4;
        t    = (e < 2) ? 0 : (e - 2) / 4;
        f    = t % 160;
        c    = t % 56;
        tick = (e >= 4) && (e % 4 == 0);
        hz4  = (f % 10) >= 5;
        return {tick, (f % 40) >= 20, (f % 20) >= 10, hz4, hz4 && (f < 20), hz4 && (f < 140), c >= 28};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearTracking();
        for (int j = 0; j < 3; j++) begin
            riseN[j] = 0;
            riseE[j][0] = 0;
            riseE[j][1] = 0;
        end
        n500 = 0; n3500 = 0;
        s07 = 0; rise07a = 0; fall07 = 0; rise07b = 0;
    endtask

    task automatic doReset(input int n);
        RESET = 1'b1;
        repeat (n) begin
            @(posedge SYSCLK); #1;
            checkOutput("reset_outputs", 32'(obsVec()), 32'd0);
        end
        RESET = 1'b0;
    endtask

    // Steps edges firstE..lastE (numbered from release), checking every cycle and recording edges.
    task automatic applyStimulus(input int firstE, input int lastE);
        logic [6:0] prev, cur;
        prev = obsVec();
        for (int e = firstE; e <= lastE; e++) begin
            @(posedge SYSCLK); #1;
            cur = obsVec();
            checkOutput($sformatf("vec_e%0d", e), 32'(cur), 32'(expVec(e)));
            for (int k = 0; k < 7; k++)
                if (tabE[k] == e) checkOutput($sformatf("table_e%0d", e), 32'(cur), 32'(tabV[k]));
            for (int j = 0; j < 3; j++)
                if (cur[3+j] && !prev[3+j] && riseN[j] < 2) begin
                    riseE[j][riseN[j]] = e;
                    riseN[j]++;
                end
            if (e < 1282 && cur[2] && !prev[2]) n500++;
            if (e < 1282 && cur[1] && !prev[1]) n3500++;
            if (s07 == 0 && cur[0] && !prev[0]) begin rise07a = e; s07 = 1; end
            else if (s07 == 1 && !cur[0] && prev[0]) begin fall07 = e; s07 = 2; end
            else if (s07 == 2 && cur[0] && !prev[0]) begin rise07b = e; s07 = 3; end
            prev = cur;
        end
    endtask

    initial begin
        RESET = 1'b1;
        BLINK_SYNC = 1'b0;
        clearTracking();

        doReset(3);
        applyStimulus(1, 4484);
        checkOutput("4hz_first_rise", 32'(riseE[0][0]), 32'd22);
        checkOutput("4hz_period", 32'(riseE[0][1] - riseE[0][0]), 32'd40);
        checkOutput("2hz_period", 32'(riseE[1][1] - riseE[1][0]), 32'd80);
        checkOutput("1hz_period", 32'(riseE[2][1] - riseE[2][0]), 32'd160);
        checkOutput("500ms_pulses_2frames", 32'(n500), 32'd4);
        checkOutput("3500ms_pulses_2frames", 32'(n3500), 32'd28);
        checkOutput("07s_high_cycles", 32'(fall07 - rise07a), 32'd112);
        checkOutput("07s_low_cycles", 32'(rise07b - fall07), 32'd112);

        doReset(1);
        clearTracking();
        applyStimulus(1, 310);
        checkOutput("4hz_at_f77", 32'(CLK_4HZ), 32'd1);
        RESET = 1'b1;
        @(posedge SYSCLK); #1;
        checkOutput("midreset_outputs", 32'(obsVec()), 32'd0);
        RESET = 1'b0;
        applyStimulus(1, 136);

        checkOutput("tick_before_sync", 32'(TICK_25MS), 32'd1);
        BLINK_SYNC = 1'b1;
        @(posedge SYSCLK); #1;
        BLINK_SYNC = 1'b0;
        checkOutput("sync_edge_tick", 32'(TICK_25MS), 32'd0);
        checkOutput("sync_edge_vec_f33", 32'(obsVec()), 32'(7'b0110001));
`ifdef LED_BLINK_SYNC_EN
        applyStimulus(1, 100);
`else
        applyStimulus(138, 240);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
